// File: rtl/spi_request_arbiter.sv
// Round-robin arbiter sharing one SPI controller among N_REQ requesters. MODE and
// CLK_RATIO are reprogrammed only on change; each grant launches one byte transfer.
module spi_request_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [2*N_REQ-1:0] i_req_mode,
  input  logic [8*N_REQ-1:0] i_req_ratio,
  input  logic [8*N_REQ-1:0] i_req_tx,
  output logic [N_REQ-1:0]   o_done,
  output logic               o_err,
  output logic [7:0]         o_rx_data,
  output logic               o_busy,
  output logic               o_spi_ws_n,
  output logic               o_spi_rs_n,
  output logic [2:0]         o_spi_addr,
  output logic [7:0]         o_spi_data,
  output logic               o_spi_request_tx,
  input  logic [7:0]         i_spi_data,
  input  logic               i_spi_ready,
  input  logic               i_spi_rx_valid
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [2:0] ADDR_MODE  = 3'd3;
  localparam logic [2:0] ADDR_RATIO = 3'd4;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    CHECK    = 4'd1,
    WR_MODE  = 4'd2,
    WR_RATIO = 4'd3,
    WAIT_RDY = 4'd4,
    TX_REQ   = 4'd5,
    TX_WAIT  = 4'd6,
    CAPTURE  = 4'd7,
    DONE     = 4'd8
  } state_t;

  state_t          state_r;
  logic [IW-1:0]   rr_ptr_r;
  logic [IW-1:0]   win_r;
  logic [1:0]      mode_r;
  logic [7:0]      ratio_r;
  logic [7:0]      tx_r;
  logic [1:0]      cur_mode_r;
  logic [7:0]      cur_ratio_r;
  logic            cfg_valid_r;
  logic [1:0]      wcnt_r;
  logic [TW-1:0]   tcnt_r;
  logic            rx_valid_d_r;

  logic            any_req_s;
  logic [IW-1:0]   winner_s;
  logic [1:0]      sel_mode_s;
  logic [7:0]      sel_ratio_s;
  logic [7:0]      sel_tx_s;
  logic            tmo_s;

  // Scan downward so the requester closest after ptr is the last (winning) assignment.
  function automatic logic [IW:0] pick(input logic [N_REQ-1:0] req, input logic [IW-1:0] ptr);
    logic [IW:0] res;
    int          idx;
    res = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (req[IW'(idx)]) begin
        res = {1'b1, IW'(idx)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [N_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign {any_req_s, winner_s} = pick(i_req, rr_ptr_r);
  assign tmo_s      = (tcnt_r == TW'(TIMEOUT_CYCLES - 1));
  assign o_spi_rs_n = 1'b1;

  // Winner's request fields, AND-OR muxed from the packed request buses.
  always_comb begin
    sel_mode_s  = 2'd0;
    sel_ratio_s = 8'd0;
    sel_tx_s    = 8'd0;
    for (int k = 0; k < N_REQ; k++) begin
      sel_mode_s  = sel_mode_s  | (i_req_mode[2*k +: 2]  & {2{winner_s == IW'(k)}});
      sel_ratio_s = sel_ratio_s | (i_req_ratio[8*k +: 8] & {8{winner_s == IW'(k)}});
      sel_tx_s    = sel_tx_s    | (i_req_tx[8*k +: 8]    & {8{winner_s == IW'(k)}});
    end
  end

  // Arbitration / configuration / transfer sequencer with registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r          <= IDLE;
      rr_ptr_r         <= IW'(N_REQ - 1);
      win_r            <= '0;
      mode_r           <= 2'd0;
      ratio_r          <= 8'd0;
      tx_r             <= 8'd0;
      cur_mode_r       <= 2'd0;
      cur_ratio_r      <= 8'd0;
      cfg_valid_r      <= 1'b0;
      wcnt_r           <= 2'd0;
      tcnt_r           <= '0;
      rx_valid_d_r     <= 1'b0;
      o_done           <= '0;
      o_err            <= 1'b0;
      o_rx_data        <= 8'd0;
      o_busy           <= 1'b0;
      o_spi_ws_n       <= 1'b1;
      o_spi_addr       <= 3'd0;
      o_spi_data       <= 8'd0;
      o_spi_request_tx <= 1'b0;
    end else begin
      rx_valid_d_r <= i_spi_rx_valid;
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            win_r    <= winner_s;
            rr_ptr_r <= winner_s;
            mode_r   <= sel_mode_s;
            ratio_r  <= sel_ratio_s;
            tx_r     <= sel_tx_s;
            o_busy   <= 1'b1;
            state_r  <= CHECK;
          end
        end
        CHECK: begin
          if (ratio_r == 8'd0) begin
            o_err     <= 1'b1;
            o_rx_data <= 8'd0;
            o_done    <= onehot(win_r);
            state_r   <= DONE;
          end else if (!cfg_valid_r || (mode_r != cur_mode_r)) begin
            o_spi_ws_n <= 1'b0;
            o_spi_addr <= ADDR_MODE;
            o_spi_data <= {6'd0, mode_r};
            wcnt_r     <= 2'd0;
            state_r    <= WR_MODE;
          end else if (ratio_r != cur_ratio_r) begin
            o_spi_ws_n <= 1'b0;
            o_spi_addr <= ADDR_RATIO;
            o_spi_data <= ratio_r;
            wcnt_r     <= 2'd0;
            state_r    <= WR_RATIO;
          end else begin
            state_r <= WAIT_RDY;
          end
        end
        WR_MODE: begin
          wcnt_r <= wcnt_r + 2'd1;
          if (wcnt_r == 2'd1) begin
            o_spi_ws_n <= 1'b1;
          end else if (wcnt_r == 2'd2) begin
            cur_mode_r <= mode_r;
            if (!cfg_valid_r || (ratio_r != cur_ratio_r)) begin
              o_spi_ws_n <= 1'b0;
              o_spi_addr <= ADDR_RATIO;
              o_spi_data <= ratio_r;
              wcnt_r     <= 2'd0;
              state_r    <= WR_RATIO;
            end else begin
              state_r <= WAIT_RDY;
            end
          end
        end
        WR_RATIO: begin
          wcnt_r <= wcnt_r + 2'd1;
          if (wcnt_r == 2'd1) begin
            o_spi_ws_n <= 1'b1;
          end else if (wcnt_r == 2'd2) begin
            cur_ratio_r <= ratio_r;
            cfg_valid_r <= 1'b1;
            state_r     <= WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          // TX byte is set up one cycle ahead of the request strobe.
          if (i_spi_ready) begin
            o_spi_data <= tx_r;
            tcnt_r     <= '0;
            state_r    <= TX_REQ;
          end
        end
        TX_REQ, TX_WAIT: begin
          if (tmo_s) begin
            o_spi_request_tx <= 1'b0;
            cfg_valid_r      <= 1'b0;
            o_err            <= 1'b1;
            o_rx_data        <= 8'd0;
            o_done           <= onehot(win_r);
            state_r          <= DONE;
          end else begin
            tcnt_r <= tcnt_r + TW'(1);
            if (state_r == TX_REQ) begin
              if (!o_spi_request_tx) begin
                o_spi_request_tx <= 1'b1;
              end else if (!i_spi_ready) begin
                o_spi_request_tx <= 1'b0;
                state_r          <= TX_WAIT;
              end
            end else if (i_spi_rx_valid && !rx_valid_d_r) begin
              state_r <= CAPTURE;
            end
          end
        end
        CAPTURE: begin
          o_rx_data <= i_spi_data;
          o_err     <= 1'b0;
          o_done    <= onehot(win_r);
          state_r   <= DONE;
        end
        DONE: begin
          o_done  <= '0;
          o_err   <= 1'b0;
          o_busy  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          o_done           <= '0;
          o_busy           <= 1'b0;
          o_spi_ws_n       <= 1'b1;
          o_spi_request_tx <= 1'b0;
          state_r          <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_request_arbiter.sv
// Bench for spi_request_arbiter: behavioural SPI controller, config/round-robin model
// and a per-cycle compare process against an expectation list.
module tb_spi_request_arbiter;
  localparam int N   = 4;
  localparam int TMO = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [2*N-1:0] req_mode;
  logic [8*N-1:0] req_ratio;
  logic [8*N-1:0] req_tx;
  logic [N-1:0]   done;
  logic           err;
  logic [7:0]     rx_data;
  logic           busy;
  logic           spi_ws_n;
  logic           spi_rs_n;
  logic [2:0]     spi_addr;
  logic [7:0]     spi_wdata;
  logic           spi_request_tx;
  logic [7:0]     spi_rdata;
  logic           spi_ready;
  logic           spi_rx_valid;

  always #5 clk = ~clk;

  spi_request_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_mode(req_mode),
    .i_req_ratio(req_ratio), .i_req_tx(req_tx), .o_done(done), .o_err(err),
    .o_rx_data(rx_data), .o_busy(busy), .o_spi_ws_n(spi_ws_n), .o_spi_rs_n(spi_rs_n),
    .o_spi_addr(spi_addr), .o_spi_data(spi_wdata), .o_spi_request_tx(spi_request_tx),
    .i_spi_data(spi_rdata), .i_spi_ready(spi_ready), .i_spi_rx_valid(spi_rx_valid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural SPI controller ----------------
  logic [7:0] ctl_reg [0:7];
  int         wr_total = 0;
  int         tx_total = 0;
  logic [2:0] wr_addr_log [0:2047];
  logic [7:0] wr_data_log [0:2047];
  logic       mute = 1'b0;
  int         flush_req = 0;

  initial begin : controller
    int         flush_seen;
    int         lat;
    logic       xfer, pend;
    logic [2:0] pend_addr;
    logic [7:0] pend_data, xtx;
    flush_seen = 0; lat = 0; xfer = 1'b0; pend = 1'b0;
    pend_addr = 3'd0; pend_data = 8'd0; xtx = 8'd0;
    for (int i = 0; i < 8; i++) ctl_reg[i] = 8'd0;
    spi_ready = 1'b1; spi_rx_valid = 1'b0; spi_rdata = 8'd0;
    forever begin
      @(negedge clk);
      if (flush_req != flush_seen) begin
        flush_seen = flush_req;
        spi_ready = 1'b1; spi_rx_valid = 1'b0; xfer = 1'b0; pend = 1'b0;
      end else begin
        if (!spi_ws_n) begin
          pend = 1'b1; pend_addr = spi_addr; pend_data = spi_wdata;
        end else if (pend) begin
          pend = 1'b0;
          ctl_reg[pend_addr] = pend_data;
          if (wr_total < 2048) begin
            wr_addr_log[wr_total] = pend_addr;
            wr_data_log[wr_total] = pend_data;
          end
          wr_total++;
        end
        if (spi_rx_valid) begin
          spi_rx_valid = 1'b0; spi_ready = 1'b1;
        end else if (xfer) begin
          if (!mute) begin
            if (lat == 0) begin
              spi_rx_valid = 1'b1;
              spi_rdata = xtx ^ 8'h99 ^ {ctl_reg[3][1:0], 6'd0} ^ (ctl_reg[4] - 8'd4);
              xfer = 1'b0;
            end else begin
              lat--;
            end
          end
        end else if (spi_ready && spi_request_tx) begin
          spi_ready = 1'b0; xfer = 1'b1; lat = int'(ctl_reg[4]); xtx = spi_wdata; tx_total++;
        end
      end
    end
  end

  // ---------------- expectation model ----------------
  int         e_k [0:511];
  logic       e_err [0:511];
  logic       e_chkrx [0:511];
  logic [7:0] e_rx [0:511];
  int         e_wr [0:511];
  int         e_tx [0:511];
  int         exp_wr = 0;
  int         exp_rd = 0;
  logic       m_valid = 1'b0;
  logic [1:0] m_mode  = 2'd0;
  logic [7:0] m_ratio = 8'd0;
  int         m_last  = N - 1;

  function automatic int rr_pick(input logic [N-1:0] mask, input int last);
    int j;
    for (int i = 1; i <= N; i++) begin
      j = (last + i) % N;
      if (mask[j[1:0]]) return j;
    end
    return -1;
  endfunction

  task automatic expect_req(input int k, input logic [1:0] mode, input logic [7:0] ratio,
                            input logic [7:0] tx, input logic to);
    e_k[exp_wr] = k;
    m_last = k;
    if (ratio == 8'd0) begin
      e_err[exp_wr] = 1'b1; e_chkrx[exp_wr] = 1'b0; e_rx[exp_wr] = 8'd0;
      e_wr[exp_wr] = 0; e_tx[exp_wr] = 0;
    end else begin
      e_wr[exp_wr] = !m_valid ? 2 : (((mode != m_mode) ? 1 : 0) + ((ratio != m_ratio) ? 1 : 0));
      m_mode = mode; m_ratio = ratio; m_valid = 1'b1;
      e_tx[exp_wr] = 1; e_chkrx[exp_wr] = 1'b1;
      if (to) begin
        e_err[exp_wr] = 1'b1; e_rx[exp_wr] = 8'd0; m_valid = 1'b0;
      end else begin
        e_err[exp_wr] = 1'b0;
        e_rx[exp_wr] = tx ^ 8'h99 ^ {mode, 6'd0} ^ (ratio - 8'd4);
      end
    end
    exp_wr++;
  endtask

  // ---------------- compare process ----------------
  initial begin : compare
    int         wr_mark, tx_mark;
    logic [N-1:0] prev_done;
    wr_mark = 0; tx_mark = 0; prev_done = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        wr_mark = wr_total; tx_mark = tx_total;
      end else begin
        chk("rs_n_tied", spi_rs_n, 1);
        if (done != '0) begin
          chk("done_single_cycle", prev_done, 0);
          if (exp_rd >= exp_wr) begin
            chk("unexpected_done", done, 0);
          end else begin
            chk("done_winner", done, 32'd1 << e_k[exp_rd]);
            chk("done_err", err, e_err[exp_rd]);
            if (e_chkrx[exp_rd]) chk("rx_data", rx_data, e_rx[exp_rd]);
            chk("cfg_writes", wr_total - wr_mark, e_wr[exp_rd]);
            chk("tx_launches", tx_total - tx_mark, e_tx[exp_rd]);
            chk("busy_in_done", busy, 1);
            exp_rd++;
          end
          wr_mark = wr_total; tx_mark = tx_total;
        end
      end
      prev_done = done;
    end
  end

  // ---------------- stimulus ----------------
  int         lat_busy, lat_rtx, t_done;
  logic [N-1:0] last_done;
  logic       last_err;
  logic [7:0] last_rx;
  int         done_order [0:7];

  task automatic wait_dones(input int n, input int budget);
    int got, cyc;
    got = 0; cyc = 0; lat_busy = -1; lat_rtx = -1; t_done = -1;
    while (got < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (busy && lat_busy < 0) lat_busy = cyc;
      if (spi_request_tx && lat_rtx < 0) lat_rtx = cyc;
      if (done != '0) begin
        for (int b = 0; b < N; b++) if (done[b]) done_order[got] = b;
        got++;
        req = req & ~done;
        last_done = done; last_err = err; last_rx = rx_data; t_done = cyc;
      end
    end
    if (got < n) begin
      chk("wait_done_timeout", got, n);
      req = '0;
    end
  endtask

  task automatic set_fields(input int k, input logic [1:0] mode, input logic [7:0] ratio,
                            input logic [7:0] tx);
    req_mode[2*k +: 2]  = mode;
    req_ratio[8*k +: 8] = ratio;
    req_tx[8*k +: 8]    = tx;
  endtask

  task automatic single(input int k, input logic [1:0] mode, input logic [7:0] ratio,
                        input logic [7:0] tx, input logic to);
    set_fields(k, mode, ratio, tx);
    expect_req(k, mode, ratio, tx, to);
    req[k] = 1'b1;
    wait_dones(1, 400);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : stimulus
    int wr0, tx0, cyc;
    logic [N-1:0] mask;
    int w;
    rst = 1'b1; req = '0; req_mode = '0; req_ratio = '0; req_tx = '0;
    repeat (3) @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rx", rx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ws_n", spi_ws_n, 1);
    chk("rst_rs_n", spi_rs_n, 1);
    chk("rst_addr", spi_addr, 0);
    chk("rst_data", spi_wdata, 0);
    chk("rst_request_tx", spi_request_tx, 0);
    rst = 1'b0;
    idle(2);

    // 1: first request programs both registers
    wr0 = wr_total;
    single(0, 2'd0, 8'd4, 8'hA5, 1'b0);
    chk("t1_done", last_done, 4'b0001);
    chk("t1_rx", last_rx, 8'h3C);
    chk("t1_err", last_err, 0);
    chk("t1_nwrites", wr_total - wr0, 2);
    chk("t1_w0_addr", wr_addr_log[wr0], 3);
    chk("t1_w0_data", wr_data_log[wr0], 0);
    chk("t1_w1_addr", wr_addr_log[wr0 + 1], 4);
    chk("t1_w1_data", wr_data_log[wr0 + 1], 4);

    // 2: config hit, no writes, grant-to-request_tx latency
    idle(2);
    wr0 = wr_total;
    single(0, 2'd0, 8'd4, 8'h5A, 1'b0);
    chk("t2_nwrites", wr_total - wr0, 0);
    chk("t2_rx", last_rx, 8'hC3);
    chk("t2_latency", lat_rtx - lat_busy, 3);

    // 4: ratio 0 aborts without any controller traffic
    wr0 = wr_total; tx0 = tx_total;
    single(2, 2'd1, 8'd0, 8'h11, 1'b0);
    chk("t4_done", last_done, 4'b0100);
    chk("t4_err", last_err, 1);
    chk("t4_nwrites", wr_total - wr0, 0);
    chk("t4_ntx", tx_total - tx0, 0);

    // park rr pointer on requester 3
    single(3, 2'd3, 8'd7, 8'h77, 1'b0);

    // 3: all four held, then 1 and 3
    mask = 4'b1111;
    for (int k = 0; k < N; k++) set_fields(k, 2'(k), 8'(4 + k), 8'(8'h20 + k));
    for (int k = 0; k < N; k++) begin
      w = rr_pick(mask, m_last);
      expect_req(w, 2'(w), 8'(4 + w), 8'(8'h20 + w), 1'b0);
      mask[w[1:0]] = 1'b0;
    end
    req = 4'b1111;
    wait_dones(4, 1600);
    chk("t3_order0", done_order[0], 0);
    chk("t3_order1", done_order[1], 1);
    chk("t3_order2", done_order[2], 2);
    chk("t3_order3", done_order[3], 3);
    @(negedge clk);
    mask = 4'b1010;
    set_fields(1, 2'd2, 8'd9, 8'h31);
    set_fields(3, 2'd0, 8'd12, 8'h33);
    w = rr_pick(mask, m_last);
    expect_req(w, (w == 1) ? 2'd2 : 2'd0, (w == 1) ? 8'd9 : 8'd12, (w == 1) ? 8'h31 : 8'h33, 1'b0);
    mask[w[1:0]] = 1'b0;
    w = rr_pick(mask, m_last);
    expect_req(w, (w == 1) ? 2'd2 : 2'd0, (w == 1) ? 8'd9 : 8'd12, (w == 1) ? 8'h31 : 8'h33, 1'b0);
    req = 4'b1010;
    wait_dones(2, 800);
    chk("t3b_order0", done_order[0], 1);
    chk("t3b_order1", done_order[1], 3);
    @(negedge clk);

    // 5: controller never answers
    mute = 1'b1;
    single(1, 2'd1, 8'd5, 8'h42, 1'b1);
    chk("t5_err", last_err, 1);
    chk("t5_rx", last_rx, 0);
    chk("t5_window", ((t_done - lat_rtx) >= TMO - 2) && ((t_done - lat_rtx) <= TMO + 2), 1);
    mute = 1'b0;
    flush_req++;
    idle(2);
    wr0 = wr_total;
    single(0, 2'd1, 8'd5, 8'h43, 1'b0);
    chk("t5_reprogram", wr_total - wr0, 2);

    // 6: reset while waiting for rx_valid
    set_fields(2, 2'd2, 8'd16, 8'h99);
    req[2] = 1'b1;
    cyc = 0;
    while (!spi_request_tx && cyc < 200) begin @(negedge clk); cyc++; end
    while (spi_request_tx && cyc < 200) begin @(negedge clk); cyc++; end
    chk("t6_reached_tx_wait", cyc < 200, 1);
    @(negedge clk);
    rst = 1'b1; req = '0;
    @(negedge clk);
    chk("t6_busy", busy, 0);
    chk("t6_ws_n", spi_ws_n, 1);
    chk("t6_request_tx", spi_request_tx, 0);
    chk("t6_done", done, 0);
    rst = 1'b0;
    flush_req++;
    m_valid = 1'b0; m_last = N - 1;
    idle(20);
    wr0 = wr_total;
    single(2, 2'd2, 8'd16, 8'h99, 1'b0);
    chk("t6_reprogram", wr_total - wr0, 2);

    // sweep over modes and ratios 4..16
    for (int i = 0; i < 255; i++) begin
      single(int'($urandom_range(3, 0)), 2'(i % 4), 8'($urandom_range(16, 4)), 8'($urandom), 1'b0);
    end

    idle(4);
    chk("all_expected_done", exp_rd, exp_wr);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
